// File: rtl/byte_unstriping_if.sv
// Lane-merge bus for byte_unstriping.
//   valid_0/lane_0, valid_1/lane_1 : striped input lanes (driven by master)
//   valid_out/data_out             : merged word stream (driven by slave)
//   sel                            : lane the merger expects next
//   error                          : sticky lane FIFO overflow flag
interface byte_unstriping_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             valid_0;
  logic [WIDTH-1:0] lane_0;
  logic             valid_1;
  logic [WIDTH-1:0] lane_1;
  logic             valid_out;
  logic [WIDTH-1:0] data_out;
  logic             sel;
  logic             error;

  modport master (
    output valid_0, lane_0, valid_1, lane_1,
    input  valid_out, data_out, sel, error
  );

  modport slave (
    input  valid_0, lane_0, valid_1, lane_1,
    output valid_out, data_out, sel, error
  );
endinterface

// File: rtl/byte_unstriping.sv
// Merges two striped lanes back into one word stream, taking words strictly in
// alternation (lane 0 first after reset). Each lane has a small FIFO to absorb
// inter-lane skew; a word arriving on the selected lane with an empty FIFO is
// bypassed straight to the output register.
//   clk_2f : sole clock, rising edge
//   reset  : asynchronous, active-low
//   bus    : slave side of byte_unstriping_if (lanes in, merged word/sel/error out)
module byte_unstriping #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input logic              clk_2f,
  input logic              reset,
  byte_unstriping_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  typedef enum logic [0:0] {StWait0 = 1'b0, StWait1 = 1'b1} state_e;

  state_e state_q, state_d;

  logic             in_valid [2];
  logic [WIDTH-1:0] in_data  [2];

  logic [WIDTH-1:0] mem_q [2][DEPTH];
  logic [PtrW-1:0]  wptr_q [2];
  logic [PtrW-1:0]  wptr_d [2];
  logic [PtrW-1:0]  rptr_q [2];
  logic [PtrW-1:0]  rptr_d [2];
  logic [CntW-1:0]  cnt_q  [2];
  logic [CntW-1:0]  cnt_d  [2];

  logic             push     [2];
  logic             pop      [2];
  logic             overflow [2];
  logic             cur;
  logic             bypass;
  logic             emit;
  logic [WIDTH-1:0] emit_data;

  logic             valid_out_q, valid_out_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             error_q, error_d;

  always_comb begin
    in_valid[0] = bus.valid_0;
    in_valid[1] = bus.valid_1;
    in_data[0]  = bus.lane_0;
    in_data[1]  = bus.lane_1;
  end

  // Next-state: FIFO bookkeeping, emit decision and selector.
  always_comb begin
    cur       = (state_q == StWait1);
    bypass    = 1'b0;
    emit      = 1'b0;
    emit_data = '0;
    state_d   = state_q;
    error_d   = error_q;
    for (int l = 0; l < 2; l++) begin
      push[l]     = 1'b0;
      pop[l]      = 1'b0;
      overflow[l] = 1'b0;
      wptr_d[l]   = wptr_q[l];
      rptr_d[l]   = rptr_q[l];
      cnt_d[l]    = cnt_q[l];
    end

    // Only the selected lane may pop; an empty selected lane with a live word bypasses.
    for (int l = 0; l < 2; l++) begin
      pop[l] = (cur == l[0]) && (cnt_q[l] != '0);
    end
    bypass = (cnt_q[cur] == '0) && in_valid[cur];

    for (int l = 0; l < 2; l++) begin
      // A same-cycle pop frees a slot, so a full lane only overflows without one.
      overflow[l] = in_valid[l] && (cnt_q[l] == CntFull) && !pop[l];
      push[l]     = in_valid[l] && !overflow[l] && !(bypass && (cur == l[0]));
      if (push[l]) wptr_d[l] = wptr_q[l] + PtrW'(1);
      if (pop[l])  rptr_d[l] = rptr_q[l] + PtrW'(1);
      unique case ({push[l], pop[l]})
        2'b10:   cnt_d[l] = cnt_q[l] + CntW'(1);
        2'b01:   cnt_d[l] = cnt_q[l] - CntW'(1);
        default: cnt_d[l] = cnt_q[l];
      endcase
      if (overflow[l]) error_d = 1'b1;
    end

    emit = pop[cur] || bypass;
    if (pop[cur]) begin
      emit_data = mem_q[cur][rptr_q[cur]];
    end else if (bypass) begin
      emit_data = in_data[cur];
    end

    if (emit) begin
      state_d = (state_q == StWait0) ? StWait1 : StWait0;
    end

    valid_out_d = emit;
    data_out_d  = emit ? emit_data : '0;
  end

  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      state_q     <= StWait0;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
      error_q     <= 1'b0;
      for (int l = 0; l < 2; l++) begin
        wptr_q[l] <= '0;
        rptr_q[l] <= '0;
        cnt_q[l]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
      error_q     <= error_d;
      for (int l = 0; l < 2; l++) begin
        wptr_q[l] <= wptr_d[l];
        rptr_q[l] <= rptr_d[l];
        cnt_q[l]  <= cnt_d[l];
      end
    end
  end

  // Storage needs no reset: counts gate every read.
  always_ff @(posedge clk_2f) begin
    for (int l = 0; l < 2; l++) begin
      if (push[l]) mem_q[l][wptr_q[l]] <= in_data[l];
    end
  end

  assign bus.valid_out = valid_out_q;
  assign bus.data_out  = data_out_q;
  assign bus.sel       = (state_q == StWait1);
  assign bus.error     = error_q;

endmodule

// File: doc/byte_unstriping.md
# byte_unstriping

Merges the two striped lanes produced by the byte-striping stage back into a single 32-bit word stream on `clk_2f`. Words are taken strictly in alternation, lane 0 first after reset, so the original word order is restored. Each lane has a small FIFO to absorb inter-lane skew, which is why the two lanes do not need to arrive aligned. The block sits directly downstream of byte striping in the datapath.

## Interface
- `WIDTH`, 32, word width of lanes and output.
- `DEPTH`, 4, per-lane FIFO depth in words; must be a power of 2 and at least 2.

- `clk_2f`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low; 0 forces reset state immediately.
- `valid_0`  in  1  lane 0 word valid this cycle.
- `lane_0`  in  WIDTH  lane 0 word.
- `valid_1`  in  1  lane 1 word valid this cycle.
- `lane_1`  in  WIDTH  lane 1 word.
- `valid_out`  out  1  `data_out` holds a merged word this cycle.
- `data_out`  out  WIDTH  merged word; 0 whenever `valid_out` = 0.
- `sel`  out  1  lane expected next (0 or 1).
- `error`  out  1  sticky overflow flag.

## Operation
- Per-lane FIFO: write pointer, read pointer, and count (0..DEPTH). A word is pushed on a rising edge when `valid_x` = 1, unless bypassed.
- Selector state `sel`:
  - WAIT_0 (`sel` = 0) expects lane 0.
  - WAIT_1 (`sel` = 1) expects lane 1.
  - The state toggles only on an emitted word.
- Emit rule each edge, for the lane indicated by `sel`:
  - **FIFO non-empty:** pop the head, drive `data_out` = head and `valid_out` = 1, toggle `sel`. A same-cycle `valid` word on that lane is pushed.
  - **FIFO empty and `valid_sel` = 1 (bypass):** `data_out` = incoming word, `valid_out` = 1, toggle `sel`. The word is not pushed.
  - **Otherwise:** `valid_out` = 0, `data_out` = 0, `sel` unchanged.
- The non-selected lane only pushes; it never emits in that cycle. At most one word is emitted per cycle.
- Overflow: a push to a lane whose count = DEPTH, with no same-cycle pop from that lane, drops the incoming word. It sets `error` = 1, which holds until reset. A push and pop on a full lane in the same cycle is legal; the count stays DEPTH.
- Pointers wrap modulo DEPTH. Count arithmetic is `clog2(DEPTH)+1` bits wide.
- Reset values (asserted asynchronously, and also when reset is applied mid-stream):
  - `valid_out` = 0, `data_out` = 0, `sel` = 0, `error` = 0.
  - Both FIFOs emptied (pointers and counts = 0).
  - All buffered words are discarded.
- The first cycle after reset deasserts waits for lane 0 regardless of lane 1 activity. Lane 1 words arriving early are buffered.

## Timing
- Outputs are registered. A word presented on the selected, empty lane in cycle N appears on `data_out` in cycle N+1 (latency 1).
- A buffered word is emitted in the first cycle its lane becomes selected.
- Back-to-back alternating input (lane 0 in cycle N, lane 1 in cycle N+1) produces output in cycles N+1 and N+2 with no bubble.
- Simultaneous `valid_0` and `valid_1` in cycle N with `sel` = 0:
  - Lane 0 word emitted in N+1.
  - Lane 1 word pushed, then emitted in N+2.
- Throughput: 1 word/cycle sustained when lanes jointly supply 1 word/cycle.

## Test plan
- Aligned stream: lane 0 = FFFFFFFF in cycle 1, lane 1 = EEEEEEEE in cycle 2, lane 0 = DDDDDDDD in cycle 3, lane 1 = CCCCCCCC in cycle 4 -> `data_out` = FFFFFFFF, EEEEEEEE, DDDDDDDD, CCCCCCCC in cycles 2–5, `valid_out` = 1 throughout, then 0 with `data_out` = 0.
- Skew: lane 1 = 00000004 arrives 2 cycles before lane 0 = 00000003 -> nothing emitted until lane 0 arrives, then 00000003 followed next cycle by 00000004; `sel` returns to 0.
- Simultaneous: `valid_0` = `valid_1` = 1 with AAAAAAAA and 99999999 in the same cycle -> AAAAAAAA then 99999999 in consecutive cycles.
- Overflow: 5 lane 1 words (00000001..00000005) with no lane 0 words, DEPTH = 4 -> `error` rises on the 5th push and stays 1. A later lane 0 word 00000007 then yields 00000007, 00000001, and so on.
- Reset mid-operation: assert `reset` = 0 with 2 words buffered on lane 1 -> all outputs 0 immediately. After release, a lane 0 word 00000007 followed by a lane 1 word 00000008 produces exactly 00000007, 00000008, with no stale words.
